// File: rtl/bitonic_sort_sequencer.sv
// Time-multiplexed bitonic sorter: loads a frame of 2^LOG_N words, runs the full
// compare-exchange schedule through one shared comparator, then drains ascending.
module bitonic_sort_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int LOG_N      = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy
);

  localparam int N = 1 << LOG_N;
  localparam logic [LOG_N-1:0] LAST_IDX  = LOG_N'(N - 1);
  localparam logic [LOG_N-1:0] LAST_PAIR = LOG_N'(N / 2 - 1);
  localparam logic [3:0]       TOP_STAGE = 4'(LOG_N);

  typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

  state_t state, state_next;

  logic [DATA_WIDTH-1:0] mem [N];
  logic [LOG_N-1:0]      wr_idx, rd_idx, pair;
  logic [3:0]            stage, step;   // log2(k) and log2(j)

  logic                  accept_in, accept_out, pass_done;
  logic [LOG_N:0]        pair_ext, low_mask, idx_lo_w, idx_hi_w;
  logic [LOG_N-1:0]      idx_lo, idx_hi;
  logic [DATA_WIDTH-1:0] lo_word, hi_word;
  logic                  ascending, do_swap;

  assign in_ready   = (state == LOAD);
  assign out_valid  = (state == DRAIN);
  assign out_data   = out_valid ? mem[rd_idx] : '0;
  assign out_last   = out_valid && (rd_idx == LAST_IDX);
  assign busy       = (state != LOAD);
  assign accept_in  = in_valid && in_ready;
  assign accept_out = out_valid && out_ready;
  assign pass_done  = (pair == LAST_PAIR) && (step == 4'd0) && (stage == TOP_STAGE);

  // Pair index p becomes element index i by inserting a 0 at bit log2(j); partner is i+j.
  always_comb begin
    pair_ext  = {1'b0, pair};
    low_mask  = ((LOG_N+1)'(1) << step) - (LOG_N+1)'(1);
    idx_lo_w  = ((pair_ext & ~low_mask) << 1) | (pair_ext & low_mask);
    idx_hi_w  = idx_lo_w | (low_mask + (LOG_N+1)'(1));
    idx_lo    = idx_lo_w[LOG_N-1:0];
    idx_hi    = idx_hi_w[LOG_N-1:0];
    ascending = (((idx_lo_w >> stage) & (LOG_N+1)'(1)) == '0);
    lo_word   = mem[idx_lo];
    hi_word   = mem[idx_hi];
    do_swap   = ascending ? (lo_word > hi_word) : (lo_word < hi_word);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (reset) state <= LOAD;
    else       state <= state_next;
  end

  // NOTE: next-state is assigned a default before the case so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      LOAD:    if (accept_in && wr_idx == LAST_IDX)   state_next = SORT;
      SORT:    if (pass_done)                          state_next = DRAIN;
      DRAIN:   if (accept_out && rd_idx == LAST_IDX)   state_next = LOAD;
      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_idx <= '0;
      rd_idx <= '0;
      pair   <= '0;
      stage  <= 4'd1;
      step   <= 4'd0;
    end else begin
      case (state)
        LOAD: if (accept_in) wr_idx <= wr_idx + LOG_N'(1);
        SORT: begin
          if (pair == LAST_PAIR) begin
            pair <= '0;
            if (step == 4'd0) begin
              if (stage == TOP_STAGE) begin
                stage <= 4'd1;
              end else begin
                stage <= stage + 4'd1;
                step  <= stage;   // new j = (2k)/2 = k
              end
            end else begin
              step <= step - 4'd1;
            end
          end else begin
            pair <= pair + LOG_N'(1);
          end
        end
        DRAIN: if (accept_out) rd_idx <= rd_idx + LOG_N'(1);
        default: ;
      endcase
    end
  end

  // NOTE: the register file is deliberately not reset; its contents are
  // overwritten by every load, and resetting it would cost a reset net per bit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (accept_in) begin
        mem[wr_idx] <= in_data;
      end else if (state == SORT && do_swap) begin
        mem[idx_lo] <= hi_word;
        mem[idx_hi] <= lo_word;
      end
    end
  end

endmodule

// File: tb/tb_bitonic_sort_sequencer.sv
// Scoreboard bench for bitonic_sort_sequencer: directed frames with hand-sorted
// expectations, plus latency, busy length, backpressure, abort and N=2 cases.
module tb_bitonic_sort_sequencer;

  typedef logic [7:0] frame_t [8];
  typedef struct { logic [7:0] d; logic last; } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic [7:0] in_data, out_data;
  logic       in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_last_b, busy_b;
  logic [7:0] in_data_b, out_data_b;

  int   checks = 0;
  int   errors = 0;
  int   busy_cyc = 0;
  bit   bp = 1'b0;
  exp_t sb[$];
  exp_t sb_b[$];

  always #5 clk = ~clk;

  bitonic_sort_sequencer #(.DATA_WIDTH(8), .LOG_N(3)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy));

  bitonic_sort_sequencer #(.DATA_WIDTH(8), .LOG_N(1)) u_dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_data(in_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_data(out_data_b), .out_last(out_last_b), .busy(busy_b));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Out-ready pattern 1,0,0 repeating while bp is set, otherwise held high.
  initial begin
    int phase = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_ready = bp ? (phase == 0) : 1'b1;
      phase = (phase + 1) % 3;
    end
  end

  always @(negedge clk) if (busy) busy_cyc++;

  // Monitor: pops the scoreboard on every output handshake and checks stall hold.
  initial begin
    bit         stalled = 1'b0;
    logic [7:0] held = '0;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (reset) begin
        stalled = 1'b0;
      end else begin
        if (out_valid) begin
          if (stalled) check("hold_data", out_data, held);
          if (out_ready) begin
            if (sb.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_out: got %0h with empty scoreboard", out_data);
            end else begin
              e = sb.pop_front();
              check("out_data", out_data, e.d);
              check("out_last", out_last, e.last);
            end
            stalled = 1'b0;
          end else begin
            stalled = 1'b1;
            held    = out_data;
          end
        end else begin
          check("idle_data", out_data, 0);
          check("idle_last", out_last, 0);
          stalled = 1'b0;
        end
        check("ready_vs_busy", in_ready, !busy);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid_b && out_ready_b) begin
      if (sb_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_out_b: got %0h with empty scoreboard", out_data_b);
      end else begin
        e = sb_b.pop_front();
        check("out_data_b", out_data_b, e.d);
        check("out_last_b", out_last_b, e.last);
      end
    end
  end

  task automatic put(input logic [7:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 300) begin
        $display("FAIL put_timeout: in_ready never rose");
        $fatal(1, "input handshake timeout");
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input frame_t w, input frame_t s, input bit gaps, input bit expect_out);
    if (expect_out) for (int i = 0; i < 8; i++) sb.push_back('{d: s[i], last: (i == 7)});
    for (int i = 0; i < 8; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      put(w[i]);
    end
    in_data = 8'hEE;   // stays valid during SORT to prove no capture
  endtask

  task automatic check_latency();
    int n = 1;
    while (n < 100) begin
      @(negedge clk);
      if (out_valid) break;
      n++;
      @(posedge clk);
    end
    check("first_out_latency", n, 25);
    repeat (3) begin @(posedge clk); #1; end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || sb.size() != 0) && n < 500);
    if (n >= 500) begin
      checks++; errors++;
      $display("FAIL idle_timeout: busy=%0b pending=%0d", busy, sb.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int b0;
    int n;
    reset = 1'b1; in_valid = 1'b0; in_data = '0;
    in_valid_b = 1'b0; in_data_b = '0; out_ready_b = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    send_frame('{5, 3, 7, 1, 8, 2, 6, 4}, '{1, 2, 3, 4, 5, 6, 7, 8}, 1'b0, 1'b1);
    check_latency();
    wait_idle();

    b0 = busy_cyc;
    send_frame('{0, 1, 2, 3, 4, 5, 6, 7}, '{0, 1, 2, 3, 4, 5, 6, 7}, 1'b0, 1'b1);
    check_latency();
    wait_idle();
    check("busy_len_sorted", busy_cyc - b0, 32);

    b0 = busy_cyc;
    send_frame('{7, 6, 5, 4, 3, 2, 1, 0}, '{0, 1, 2, 3, 4, 5, 6, 7}, 1'b0, 1'b1);
    check_latency();
    wait_idle();
    check("busy_len_reverse", busy_cyc - b0, 32);

    send_frame('{9, 9, 8'hFF, 0, 9, 0, 8'hFF, 9}, '{0, 0, 9, 9, 9, 9, 8'hFF, 8'hFF}, 1'b0, 1'b1);
    check_latency();
    wait_idle();

    send_frame('{8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA},
               '{8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA}, 1'b0, 1'b1);
    check_latency();
    wait_idle();

    bp = 1'b1;
    send_frame('{200, 100, 150, 50, 250, 0, 25, 75}, '{0, 25, 50, 75, 100, 150, 200, 250}, 1'b0, 1'b1);
    check_latency();
    wait_idle();
    bp = 1'b0;
    @(posedge clk); #1;

    send_frame('{10, 40, 30, 20, 80, 70, 60, 50}, '{10, 20, 30, 40, 50, 60, 70, 80}, 1'b1, 1'b1);
    check_latency();
    wait_idle();

    // Abort in SORT cycle 10: the frame must vanish without output.
    send_frame('{1, 2, 3, 4, 5, 6, 7, 8}, '{0, 0, 0, 0, 0, 0, 0, 0}, 1'b0, 1'b0);
    in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 1);
    @(posedge clk); #1;
    send_frame('{2, 1, 4, 3, 6, 5, 8, 7}, '{1, 2, 3, 4, 5, 6, 7, 8}, 1'b0, 1'b1);
    check_latency();
    wait_idle();

    // N=2 instance: frame 7,3 sorts to 3,7 after a single SORT cycle.
    sb_b.push_back('{d: 8'd3, last: 1'b0});
    sb_b.push_back('{d: 8'd7, last: 1'b1});
    in_valid_b = 1'b1; in_data_b = 8'd7;
    @(negedge clk); check("b_ready0", in_ready_b, 1);
    @(posedge clk); #1;
    in_data_b = 8'd3;
    @(negedge clk); check("b_ready1", in_ready_b, 1);
    @(posedge clk); #1;
    in_valid_b = 1'b0;
    n = 1;
    while (n < 50) begin
      @(negedge clk);
      if (out_valid_b) break;
      n++;
      @(posedge clk);
    end
    check("b_latency", n, 2);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("b_idle", busy_b, 0);
    check("sb_empty", sb.size(), 0);
    check("sb_b_empty", sb_b.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bitonic_sort_sequencer.md
# bitonic_sort_sequencer

Single-lane bitonic sorter controller for the sorter datapath. It collects a frame of N = 2^LOG_N words and walks the full bitonic compare-exchange schedule using one shared compare-exchange unit over an internal register file. It then streams the frame out in ascending order. It sits between the input word stream and the downstream consumer, replacing an unrolled network of bitonic nodes with a time-multiplexed one.

## Interface
- DATA_WIDTH, 8, width of each data word (unsigned)
- LOG_N, 3, log2 of frame size; N = 2^LOG_N, legal range 1..6

- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- in_valid  input  1  in_data holds a word
- in_ready  output  1  block accepts a word this cycle
- in_data  input  DATA_WIDTH  input word
- out_valid  output  1  out_data holds a sorted word
- out_ready  input  1  consumer accepts out_data this cycle
- out_data  output  DATA_WIDTH  sorted word; 0 when out_valid low
- out_last  output  1  high with the final (Nth) word of a frame
- busy  output  1  high in SORT or DRAIN

## Operation
- States: LOAD, SORT, DRAIN. Reset enters LOAD with all counters at 0. On reset, out_valid=0, out_data=0, out_last=0, busy=0, in_ready=1. Register-file contents are don't-care.
- LOAD: in_ready=1. Each in_valid&&in_ready writes a[wr_idx] and increments wr_idx. Acceptance of word N-1 moves the block to SORT and clears wr_idx.
- SORT: in_ready=0. One compare-exchange per cycle. Counters are k (2,4,..,N), j (k/2 down to 1) and pair index p (0..N/2-1).
  - i = p with a 0 bit inserted at bit position log2(j); l = i+j.
  - Ascending if (i & k)==0: swap when a[i] > a[l]. Otherwise descending: swap when a[i] < a[l].
  - Equal words never swap.
  - Both entries are written at the same clock edge.
- Counter advance order: p first. When p wraps, j halves. When j passes 1, k doubles and j resets to k/2. After the last pair of k=N, j=1, the block moves to DRAIN.
- SORT length S = (N/2)·LOG_N·(LOG_N+1)/2 cycles. For N=8, S=24; for N=2, S=1.
- DRAIN: out_valid=1 and out_data=a[rd_idx]. out_last=1 when rd_idx==N-1. rd_idx increments on out_valid&&out_ready. Acceptance of the last word moves the block to LOAD and clears rd_idx.
- out_data holds stable while out_valid&&!out_ready.
- Input words are unsigned. There is no arithmetic beyond comparison, so no width growth.

## Timing
- Last input word accepted in cycle t: SORT occupies cycles t+1..t+S, and out_valid is first high in cycle t+S+1.
- With out_ready held high, DRAIN lasts exactly N cycles. LOAD is entered in the cycle after the last-word handshake, and in_ready=1 in that cycle.
- Minimum frame period is N (LOAD) + S + N (DRAIN) cycles. LOAD does not overlap DRAIN.
- in_ready and out_valid/out_last/out_data are decoded from the registered state and counters. There is no combinational path from in_valid or out_ready to them.
- in_valid while in_ready=0 is ignored; the word is not captured.
- reset high in any state (including mid-SORT or mid-DRAIN) aborts the frame. On the next cycle the outputs are at reset values and in LOAD. The partial frame is discarded and not re-emitted.
- reset wins over a coincident input or output handshake.

## Test plan
- N=8, load 5,3,7,1,8,2,6,4 back-to-back, out_ready=1 -> out_valid rises 25 cycles after the last accept. Output is 1,2,3,4,5,6,7,8, with out_last only on 8.
- Already sorted 0..7 and reverse 7..0 -> both emit 0..7. busy is high for exactly 24+8 cycles.
- Duplicates 9,9,0xFF,0,9,0,0xFF,9 -> 0,0,9,9,9,9,0xFF,0xFF. All-equal 0xAA frame -> eight 0xAA.
- Output backpressure: out_ready toggling 1,0,0,1,... -> out_data holds during stalls. There are no drops or duplicates, and in_ready stays 0 until the last word is accepted.
- Input gaps: in_valid with random idle cycles -> the frame is still collected correctly. in_valid asserted during SORT/DRAIN -> no capture.
- reset pulse mid-SORT (cycle 10 of 24) -> next cycle in LOAD with out_valid=0 and busy=0. A following frame of 2,1,4,3,6,5,8,7 sorts correctly. Repeat with LOG_N=1: frame 7,3 -> 3,7 with S=1.
